// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single MMU memory port between instruction
// fetch (IF) and the data memory unit (DM).
//
// Arbitration is combinational and fixed-priority (DM first). An
// anti-starvation counter forces an IF win once IF has been denied
// STARVE_LIMIT consecutive cycles while requesting. A grant may issue every
// cycle. The memory is synchronous, so the response (read data or write ack)
// appears exactly one cycle after the grant. A small response-owner FSM
// remembers which requester that response belongs to.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   if_req/if_addr              IF read request (held until if_gnt)
//   if_gnt                      IF accepted this cycle (combinational)
//   if_rvalid/if_rdata          IF read response, one cycle after if_gnt
//   dm_req/dm_addr/dm_we/dm_wdata  DM request (held until dm_gnt)
//   dm_gnt                      DM accepted this cycle (combinational)
//   dm_rvalid/dm_rdata          DM read data or write ack (rdata 0 on ack)
//   mem_addr/mem_we/mem_wdata   MMU request side
//   mem_rdata                   MMU read data, valid one cycle after address
//
// Optional build macro MEM_ARB_STATS_EN adds the statistics outputs
// stat_if_grants, stat_dm_grants and stat_conflicts (CNT_W bits each,
// wrapping counters).
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_if_grants,
  output logic [CNT_W-1:0]  stat_dm_grants,
  output logic [CNT_W-1:0]  stat_conflicts
`endif
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  // Response owner for the cycle after a grant.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RESP_IF = 2'd1;
  localparam logic [1:0] RESP_DM = 2'd2;

  logic [1:0]      state;
  logic            resp_we;     // DM grant that produced this response was a write
  logic [SC_W-1:0] starve_cnt;
  logic            if_win, dm_win;

  // Grants are masked while reset is high so every output reads 0 in reset.
  always_comb begin
    if_win = !reset && if_req && (!dm_req || (starve_cnt == STARVE_MAX));
    dm_win = !reset && dm_req && !if_win;
  end

  assign if_gnt    = if_win;
  assign dm_gnt    = dm_win;
  assign mem_addr  = dm_win ? dm_addr  : (if_win ? if_addr : '0);
  assign mem_we    = dm_win & dm_we;
  assign mem_wdata = dm_win ? dm_wdata : '0;

  assign if_rvalid = (state == RESP_IF);
  assign dm_rvalid = (state == RESP_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = (dm_rvalid && !resp_we) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp_we    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state   <= if_win ? RESP_IF : (dm_win ? RESP_DM : IDLE);
      resp_we <= dm_win & dm_we;
      // Counts consecutive lost cycles; saturates so the forced win holds
      // until IF is actually granted.
      if (!if_req || if_win)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_if_grants <= '0;
      stat_dm_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      if (if_win)           stat_if_grants <= stat_if_grants + 1'b1;
      if (dm_win)           stat_dm_grants <= stat_dm_grants + 1'b1;
      if (if_req && dm_req) stat_conflicts <= stat_conflicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_if_grants, stat_dm_grants, stat_conflicts;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_dm_grants(stat_dm_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  // Synchronous memory: read data is the old contents, one cycle later.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one full cycle; inputs are driven and outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_out(input string tag);
    chk({tag, " if_gnt"},    32'(if_gnt),    32'd0);
    chk({tag, " dm_gnt"},    32'(dm_gnt),    32'd0);
    chk({tag, " if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, " dm_rvalid"}, 32'(dm_rvalid), 32'd0);
    chk({tag, " if_rdata"},  if_rdata,       32'd0);
    chk({tag, " dm_rdata"},  dm_rdata,       32'd0);
    chk({tag, " mem_addr"},  mem_addr,       32'd0);
    chk({tag, " mem_we"},    32'(mem_we),    32'd0);
    chk({tag, " mem_wdata"}, mem_wdata,      32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'hDEADBEEF;  // address 0x100
    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    // Requests during reset must not be granted.
    if_req = 1'b1; if_addr = 32'h100;
    #1 idle_out("reset");
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();

    // IF only
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("if gnt",      32'(if_gnt),    32'd1);
    chk("if dm_gnt",   32'(dm_gnt),    32'd0);
    chk("if mem_addr", mem_addr,       32'h100);
    chk("if mem_we",   32'(mem_we),    32'd0);
    step();
    if_req = 1'b0;
    #1;
    chk("if rvalid",   32'(if_rvalid), 32'd1);
    chk("if rdata",    if_rdata,       32'hDEADBEEF);
    chk("if dm_rvalid",32'(dm_rvalid), 32'd0);
    step();
    chk("if rvalid drop", 32'(if_rvalid), 32'd0);

    // DM write
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h12345678;
    #1;
    chk("wr gnt",      32'(dm_gnt),    32'd1);
    chk("wr mem_we",   32'(mem_we),    32'd1);
    chk("wr mem_addr", mem_addr,       32'h2000);
    chk("wr mem_wdata",mem_wdata,      32'h12345678);
    step();
    dm_req = 1'b0; dm_we = 1'b0;
    #1;
    chk("wr ack",      32'(dm_rvalid), 32'd1);
    chk("wr rdata",    dm_rdata,       32'd0);
    chk("wr mem_we off", 32'(mem_we),  32'd0);
    step();

    // DM read back
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_wdata = 32'hFFFF0000;
    #1;
    chk("rd gnt",      32'(dm_gnt),    32'd1);
    chk("rd mem_wdata",mem_wdata,      32'hFFFF0000);
    chk("rd mem_we",   32'(mem_we),    32'd0);
    step();
    dm_req = 1'b0;
    #1;
    chk("rd rvalid",   32'(dm_rvalid), 32'd1);
    chk("rd rdata",    dm_rdata,       32'h12345678);
    step();

    // Pipelining: IF then DM read back-to-back
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("pipe if_gnt", 32'(if_gnt), 32'd1);
    step();
    if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    #1;
    chk("pipe dm_gnt",    32'(dm_gnt),    32'd1);
    chk("pipe if_rvalid", 32'(if_rvalid), 32'd1);
    chk("pipe if_rdata",  if_rdata,       32'hDEADBEEF);
    chk("pipe dm_rvalid0",32'(dm_rvalid), 32'd0);
    step();
    dm_req = 1'b0;
    #1;
    chk("pipe dm_rvalid", 32'(dm_rvalid), 32'd1);
    chk("pipe if_rvalid0",32'(if_rvalid), 32'd0);
    chk("pipe dm_rdata",  dm_rdata,       32'h12345678);
    step();

    // Reset while a DM read response is pending
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    #1 chk("rst dm_gnt", 32'(dm_gnt), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    dm_req = 1'b0;
    #1 idle_out("rst mid");
    @(negedge clk);
    reset = 1'b0;
    step();
    idle_out("rst after");

    // Contention for 10 cycles, counters and stats start from reset
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("cont%0d if_gnt", c), 32'(if_gnt), 32'((c == 4) || (c == 9)));
      chk($sformatf("cont%0d dm_gnt", c), 32'(dm_gnt), 32'(!((c == 4) || (c == 9))));
      chk($sformatf("cont%0d addr", c), mem_addr, ((c == 4) || (c == 9)) ? 32'h100 : 32'h2000);
      if (c > 0) begin
        chk($sformatf("cont%0d if_rvalid", c), 32'(if_rvalid), 32'(c == 5));
        chk($sformatf("cont%0d dm_rvalid", c), 32'(dm_rvalid), 32'(c != 5));
      end
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    #1;
    chk("cont tail if_rvalid", 32'(if_rvalid), 32'd1);
    chk("cont tail if_rdata",  if_rdata,       32'hDEADBEEF);
`ifdef MEM_ARB_STATS_EN
    chk("stat conflicts", 32'(stat_conflicts), 32'd10);
    chk("stat if",        32'(stat_if_grants), 32'd2);
    chk("stat dm",        32'(stat_dm_grants), 32'd8);
`endif
    step();
    chk("end idle", 32'(if_rvalid | dm_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
